// File: rtl/video_pkg.sv
// Shared definitions for the TX video output path: default OSD palette,
// blend mode encodings and the channel bit-replication helper.
package video_pkg;

    localparam int PAL_DEFAULT_DEPTH = 4;

    localparam logic [23:0] OSD_DEFAULT_PAL [PAL_DEFAULT_DEPTH] = '{
        24'h000000, 24'h0000ff, 24'hffff00, 24'hffffff
    };

    localparam logic BLEND_OPAQUE = 1'b0;
    localparam logic BLEND_HALF   = 1'b1;

    // Output bit (OUT-1-k) of an expanded channel takes this input bit:
    // MSB-first replication of the input word.
    function automatic int expand_src_bit(input int k, input int in_bits);
        return in_bits - 1 - (k % in_bits);
    endfunction

    function automatic logic [23:0] pal_default(input int idx);
        logic [23:0] v;
        if ((idx >= 0) && (idx < PAL_DEFAULT_DEPTH)) begin
            v = OSD_DEFAULT_PAL[idx[1:0]];
        end else begin
            v = 24'h000000;
        end
        return v;
    endfunction

endpackage

// File: rtl/osd_palette.sv
// OSD colour palette: register file with one write port and one registered
// read port; a read of the address being written returns the old entry.
module osd_palette
    import video_pkg::*;
#(
    parameter int CBITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CBITS-1:0] waddr,
    input  logic [23:0]      wdata,
    input  logic [CBITS-1:0] raddr,
    output logic [23:0]      rdata
);

    localparam int DEPTH = 2 ** CBITS;

    logic [23:0] mem_r [DEPTH];
    logic [23:0] rdata_r;

    // Palette storage, restored to the default colours on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= pal_default(i);
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 24'h000000;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/video_out_overlay.sv
// TX output stage: expands video to the TX width, overlays OSD pixels from a
// palette (opaque or 50% blend) and applies frame-shadowed sync polarity.
module video_out_overlay
    import video_pkg::*;
#(
    parameter int IN_BITS   = 5,
    parameter int OUT_BITS  = 8,
    parameter int OSD_CBITS = 2
) (
    input  logic                 PCLK_i,
    input  logic                 reset,
    input  logic [IN_BITS-1:0]   R_i,
    input  logic [IN_BITS-1:0]   G_i,
    input  logic [IN_BITS-1:0]   B_i,
    input  logic                 HSYNC_i,
    input  logic                 VSYNC_i,
    input  logic                 DE_i,
    input  logic                 osd_enable_i,
    input  logic [OSD_CBITS-1:0] osd_color_i,
    input  logic                 pal_we_i,
    input  logic [OSD_CBITS-1:0] pal_addr_i,
    input  logic [23:0]          pal_data_i,
    input  logic                 blend_mode_i,
    input  logic                 hs_pol_i,
    input  logic                 vs_pol_i,
    output logic [OUT_BITS-1:0]  R_o,
    output logic [OUT_BITS-1:0]  G_o,
    output logic [OUT_BITS-1:0]  B_o,
    output logic                 HSYNC_o,
    output logic                 VSYNC_o,
    output logic                 DE_o,
    output logic                 frame_start_o
);

    logic [OUT_BITS-1:0]  r_exp_s, g_exp_s, b_exp_s;
    logic [OUT_BITS-1:0]  r1_r, g1_r, b1_r, r2_r, g2_r, b2_r;
    logic                 hs1_r, vs1_r, de1_r, osd_en1_r, hs2_r, vs2_r, de2_r, osd_en2_r;
    logic [OSD_CBITS-1:0] osd_col1_r, pal_addr1_r;
    logic                 pal_we1_r;
    logic [23:0]          pal_data1_r, pal_q_s;
    logic                 blend1_r, hsp1_r, vsp1_r, blend2_r, hsp2_r, vsp2_r;
    logic                 vs_fall2_r;
    logic                 blend_sh_r, hsp_sh_r, vsp_sh_r;
    logic                 blend_eff_s, hsp_eff_s, vsp_eff_s;
    logic [OUT_BITS-1:0]  pal_r_s, pal_g_s, pal_b_s;
    logic [OUT_BITS:0]    sum_r_s, sum_g_s, sum_b_s;
    logic [OUT_BITS-1:0]  mix_r_s, mix_g_s, mix_b_s;

    for (genvar k = 0; k < OUT_BITS; k++) begin : g_expand
        localparam int SRC = expand_src_bit(k, IN_BITS);
        assign r_exp_s[OUT_BITS-1-k] = R_i[SRC];
        assign g_exp_s[OUT_BITS-1-k] = G_i[SRC];
        assign b_exp_s[OUT_BITS-1-k] = B_i[SRC];
    end

    // S1: register every input, video already expanded to the TX width
    always_ff @(posedge PCLK_i or posedge reset) begin
        if (reset) begin
            r1_r        <= '0;
            g1_r        <= '0;
            b1_r        <= '0;
            hs1_r       <= 1'b1;
            vs1_r       <= 1'b1;
            de1_r       <= 1'b0;
            osd_en1_r   <= 1'b0;
            osd_col1_r  <= '0;
            pal_we1_r   <= 1'b0;
            pal_addr1_r <= '0;
            pal_data1_r <= 24'h000000;
            blend1_r    <= BLEND_OPAQUE;
            hsp1_r      <= 1'b0;
            vsp1_r      <= 1'b0;
        end else begin
            r1_r        <= r_exp_s;
            g1_r        <= g_exp_s;
            b1_r        <= b_exp_s;
            hs1_r       <= HSYNC_i;
            vs1_r       <= VSYNC_i;
            de1_r       <= DE_i;
            osd_en1_r   <= osd_enable_i;
            osd_col1_r  <= osd_color_i;
            pal_we1_r   <= pal_we_i;
            pal_addr1_r <= pal_addr_i;
            pal_data1_r <= pal_data_i;
            blend1_r    <= blend_mode_i;
            hsp1_r      <= hs_pol_i;
            vsp1_r      <= vs_pol_i;
        end
    end

    // Write and read share a clock edge, so a same-pixel read sees the old entry
    osd_palette #(
        .CBITS (OSD_CBITS)
    ) u_palette (
        .clk   (PCLK_i),
        .rst   (reset),
        .we    (pal_we1_r),
        .waddr (pal_addr1_r),
        .wdata (pal_data1_r),
        .raddr (osd_col1_r),
        .rdata (pal_q_s)
    );

    // S2: delay video alongside the palette read and flag the vsync leading edge
    always_ff @(posedge PCLK_i or posedge reset) begin
        if (reset) begin
            r2_r       <= '0;
            g2_r       <= '0;
            b2_r       <= '0;
            hs2_r      <= 1'b1;
            vs2_r      <= 1'b1;
            de2_r      <= 1'b0;
            osd_en2_r  <= 1'b0;
            blend2_r   <= BLEND_OPAQUE;
            hsp2_r     <= 1'b0;
            vsp2_r     <= 1'b0;
            vs_fall2_r <= 1'b0;
        end else begin
            r2_r       <= r1_r;
            g2_r       <= g1_r;
            b2_r       <= b1_r;
            hs2_r      <= hs1_r;
            vs2_r      <= vs1_r;
            de2_r      <= de1_r;
            osd_en2_r  <= osd_en1_r;
            blend2_r   <= blend1_r;
            hsp2_r     <= hsp1_r;
            vsp2_r     <= vsp1_r;
            vs_fall2_r <= vs2_r & ~vs1_r;
        end
    end

    // Frame shadows: mode and polarities only change at a vsync leading edge
    always_ff @(posedge PCLK_i or posedge reset) begin
        if (reset) begin
            blend_sh_r <= BLEND_OPAQUE;
            hsp_sh_r   <= 1'b0;
            vsp_sh_r   <= 1'b0;
        end else if (vs_fall2_r) begin
            blend_sh_r <= blend2_r;
            hsp_sh_r   <= hsp2_r;
            vsp_sh_r   <= vsp2_r;
        end else begin
            blend_sh_r <= blend_sh_r;
            hsp_sh_r   <= hsp_sh_r;
            vsp_sh_r   <= vsp_sh_r;
        end
    end

    assign pal_r_s = pal_q_s[23 -: OUT_BITS];
    assign pal_g_s = pal_q_s[15 -: OUT_BITS];
    assign pal_b_s = pal_q_s[7 -: OUT_BITS];

    // S3 mixer; the edge pixel already uses the newly captured shadow values
    always_comb begin
        blend_eff_s = vs_fall2_r ? blend2_r : blend_sh_r;
        hsp_eff_s   = vs_fall2_r ? hsp2_r : hsp_sh_r;
        vsp_eff_s   = vs_fall2_r ? vsp2_r : vsp_sh_r;
        sum_r_s     = {1'b0, pal_r_s} + {1'b0, r2_r};
        sum_g_s     = {1'b0, pal_g_s} + {1'b0, g2_r};
        sum_b_s     = {1'b0, pal_b_s} + {1'b0, b2_r};
        mix_r_s     = '0;
        mix_g_s     = '0;
        mix_b_s     = '0;
        if (!de2_r) begin
            mix_r_s = '0;
            mix_g_s = '0;
            mix_b_s = '0;
        end else if (!osd_en2_r) begin
            mix_r_s = r2_r;
            mix_g_s = g2_r;
            mix_b_s = b2_r;
        end else begin
            case (blend_eff_s)
                BLEND_OPAQUE: begin
                    mix_r_s = pal_r_s;
                    mix_g_s = pal_g_s;
                    mix_b_s = pal_b_s;
                end
                BLEND_HALF: begin
                    mix_r_s = OUT_BITS'(sum_r_s >> 1);
                    mix_g_s = OUT_BITS'(sum_g_s >> 1);
                    mix_b_s = OUT_BITS'(sum_b_s >> 1);
                end
                default: begin
                    mix_r_s = pal_r_s;
                    mix_g_s = pal_g_s;
                    mix_b_s = pal_b_s;
                end
            endcase
        end
    end

    // S3 output registers; polarity 1 turns the active-low input syncs active-high
    always_ff @(posedge PCLK_i or posedge reset) begin
        if (reset) begin
            R_o           <= '0;
            G_o           <= '0;
            B_o           <= '0;
            HSYNC_o       <= 1'b1;
            VSYNC_o       <= 1'b1;
            DE_o          <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            R_o           <= mix_r_s;
            G_o           <= mix_g_s;
            B_o           <= mix_b_s;
            HSYNC_o       <= hs2_r ^ hsp_eff_s;
            VSYNC_o       <= vs2_r ^ vsp_eff_s;
            DE_o          <= de2_r;
            frame_start_o <= vs_fall2_r;
        end
    end

endmodule

// File: tb/tb_video_out_overlay.sv
// Scoreboard bench for video_out_overlay: a behavioural model predicts each
// output pixel when its input is driven; a monitor compares on every cycle.
module tb_video_out_overlay;

    localparam int IN_BITS   = 5;
    localparam int OUT_BITS  = 8;
    localparam int OSD_CBITS = 2;

    logic                 PCLK_i = 1'b0;
    logic                 reset;
    logic [IN_BITS-1:0]   R_i, G_i, B_i;
    logic                 HSYNC_i, VSYNC_i, DE_i, osd_enable_i;
    logic [OSD_CBITS-1:0] osd_color_i, pal_addr_i;
    logic                 pal_we_i, blend_mode_i, hs_pol_i, vs_pol_i;
    logic [23:0]          pal_data_i;
    logic [OUT_BITS-1:0]  R_o, G_o, B_o;
    logic                 HSYNC_o, VSYNC_o, DE_o, frame_start_o;

    video_out_overlay #(
        .IN_BITS   (IN_BITS),
        .OUT_BITS  (OUT_BITS),
        .OSD_CBITS (OSD_CBITS)
    ) dut (
        .PCLK_i        (PCLK_i),
        .reset         (reset),
        .R_i           (R_i),
        .G_i           (G_i),
        .B_i           (B_i),
        .HSYNC_i       (HSYNC_i),
        .VSYNC_i       (VSYNC_i),
        .DE_i          (DE_i),
        .osd_enable_i  (osd_enable_i),
        .osd_color_i   (osd_color_i),
        .pal_we_i      (pal_we_i),
        .pal_addr_i    (pal_addr_i),
        .pal_data_i    (pal_data_i),
        .blend_mode_i  (blend_mode_i),
        .hs_pol_i      (hs_pol_i),
        .vs_pol_i      (vs_pol_i),
        .R_o           (R_o),
        .G_o           (G_o),
        .B_o           (B_o),
        .HSYNC_o       (HSYNC_o),
        .VSYNC_o       (VSYNC_o),
        .DE_o          (DE_o),
        .frame_start_o (frame_start_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    // reference model state
    logic [23:0] pal_m [4];
    bit          blend_m, hsp_m, vsp_m, vs_prev_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int expand(input int x);
        return ((x << (OUT_BITS - IN_BITS)) | (x >> (2 * IN_BITS - OUT_BITS))) & 255;
    endfunction

    task automatic model_reset();
        pal_m[0]  = 24'h000000;
        pal_m[1]  = 24'h0000ff;
        pal_m[2]  = 24'hffff00;
        pal_m[3]  = 24'hffffff;
        blend_m   = 1'b0;
        hsp_m     = 1'b0;
        vsp_m     = 1'b0;
        vs_prev_m = 1'b1;
    endtask

    task automatic push_reset_value();
        exp_t e;
        e = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};
        sb_q.push_back(e);
    endtask

    // predict the output pixel for the inputs currently driven
    task automatic model_step();
        exp_t        e;
        int          vid[3], pal[3], res[3];
        logic [23:0] p;
        bit          edge_seen;
        edge_seen = vs_prev_m && !VSYNC_i;
        vs_prev_m = VSYNC_i;
        if (edge_seen) begin
            blend_m = blend_mode_i;
            hsp_m   = hs_pol_i;
            vsp_m   = vs_pol_i;
        end
        vid[0] = expand(int'(R_i));
        vid[1] = expand(int'(G_i));
        vid[2] = expand(int'(B_i));
        p      = pal_m[osd_color_i];
        pal[0] = int'(p[23:16]);
        pal[1] = int'(p[15:8]);
        pal[2] = int'(p[7:0]);
        for (int c = 0; c < 3; c++) begin
            if (!DE_i)              res[c] = 0;
            else if (!osd_enable_i) res[c] = vid[c];
            else if (!blend_m)      res[c] = pal[c];
            else                    res[c] = (pal[c] + vid[c]) / 2;
        end
        e.r  = 8'(res[0]);
        e.g  = 8'(res[1]);
        e.b  = 8'(res[2]);
        e.hs = HSYNC_i ^ hsp_m;
        e.vs = VSYNC_i ^ vsp_m;
        e.de = DE_i;
        e.fs = edge_seen;
        sb_q.push_back(e);
        if (pal_we_i) pal_m[pal_addr_i] = pal_data_i;
    endtask

    task automatic cycle();
        model_step();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic set_idle();
        R_i = '0; G_i = '0; B_i = '0;
        HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0;
        osd_enable_i = 1'b0; osd_color_i = '0;
        pal_we_i = 1'b0; pal_addr_i = '0; pal_data_i = 24'h0;
        blend_mode_i = 1'b0; hs_pol_i = 1'b0; vs_pol_i = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        sb_q.delete();
        reset = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge PCLK_i);
        #1;
        reset = 1'b0;
        repeat (3) push_reset_value();
        mon_en = 1'b1;
    endtask

    task automatic chk_rgb(input string name, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        chk({name, "_R"}, 32'(R_o), 32'(r));
        chk({name, "_G"}, 32'(G_o), 32'(g));
        chk({name, "_B"}, 32'(B_o), 32'(b));
    endtask

    // monitor: one output pixel per cycle, compared on the falling edge
    always @(negedge PCLK_i) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_R", 32'(R_o), 32'(mon_e.r));
                chk("sb_G", 32'(G_o), 32'(mon_e.g));
                chk("sb_B", 32'(B_o), 32'(mon_e.b));
                chk("sb_HS", 32'(HSYNC_o), 32'(mon_e.hs));
                chk("sb_VS", 32'(VSYNC_o), 32'(mon_e.vs));
                chk("sb_DE", 32'(DE_o), 32'(mon_e.de));
                chk("sb_FS", 32'(frame_start_o), 32'(mon_e.fs));
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_idle();
        #2;
        chk("rst_R", 32'(R_o), 32'h0);
        chk("rst_HS", 32'(HSYNC_o), 32'h1);
        do_reset();

        // plain video expansion
        R_i = 5'h1f; G_i = 5'h10; B_i = 5'h00; DE_i = 1'b1;
        repeat (4) cycle();
        chk_rgb("video", 8'hff, 8'h84, 8'h00);

        // opaque OSD from the default palette
        osd_enable_i = 1'b1; osd_color_i = 2'd1;
        repeat (4) cycle();
        chk_rgb("osd1", 8'h00, 8'h00, 8'hff);
        osd_color_i = 2'd2;
        repeat (4) cycle();
        chk_rgb("osd2", 8'hff, 8'hff, 8'h00);

        // palette write: same-cycle read is old, next cycle is new
        osd_color_i = 2'd3; pal_we_i = 1'b1; pal_addr_i = 2'd3; pal_data_i = 24'h123456;
        cycle();
        pal_we_i = 1'b0;
        cycle();
        cycle();
        chk_rgb("pal_old", 8'hff, 8'hff, 8'hff);
        cycle();
        chk_rgb("pal_new", 8'h12, 8'h34, 8'h56);

        // blend request mid-frame only applies from the vsync edge
        pal_we_i = 1'b1; pal_data_i = 24'hffffff;
        cycle();
        pal_we_i = 1'b0; blend_mode_i = 1'b1;
        R_i = '0; G_i = '0; B_i = '0;
        repeat (4) cycle();
        chk_rgb("blend_pending", 8'hff, 8'hff, 8'hff);
        VSYNC_i = 1'b0;
        repeat (3) cycle();
        chk_rgb("blend_on", 8'h7f, 8'h7f, 8'h7f);
        chk("frame_start", 32'(frame_start_o), 32'h1);
        repeat (12) cycle();

        // vsync polarity shadowed until the next edge
        VSYNC_i = 1'b1;
        repeat (5) cycle();
        vs_pol_i = 1'b1;
        repeat (5) cycle();
        chk("vs_pol_pending", 32'(VSYNC_o), 32'h1);
        VSYNC_i = 1'b0;
        repeat (3) cycle();
        chk("vs_pol_on", 32'(VSYNC_o), 32'h1);
        chk("hs_unaffected", 32'(HSYNC_o), 32'h1);
        chk("frame_start2", 32'(frame_start_o), 32'h1);
        repeat (5) cycle();

        // randomized frames with palette writes, mode/polarity changes and vsync glitches
        for (int t = 0; t < 3000; t++) begin
            HSYNC_i      = ((t % 25) < 4) ? 1'b0 : 1'b1;
            VSYNC_i      = ((t % 300) < 30) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) == 0) VSYNC_i = ~VSYNC_i;
            DE_i         = ((t % 25) >= 6) && ((t % 300) >= 40);
            R_i          = IN_BITS'($urandom);
            G_i          = IN_BITS'($urandom);
            B_i          = IN_BITS'($urandom);
            osd_enable_i = ($urandom_range(0, 2) == 0);
            osd_color_i  = OSD_CBITS'($urandom);
            pal_we_i     = ($urandom_range(0, 19) == 0);
            pal_addr_i   = OSD_CBITS'($urandom);
            pal_data_i   = 24'($urandom);
            if ($urandom_range(0, 39) == 0) blend_mode_i = ~blend_mode_i;
            if ($urandom_range(0, 59) == 0) hs_pol_i = ~hs_pol_i;
            if ($urandom_range(0, 59) == 0) vs_pol_i = ~vs_pol_i;
            cycle();
        end

        // asynchronous reset mid-line
        set_idle();
        DE_i = 1'b1; osd_enable_i = 1'b1; osd_color_i = 2'd3;
        pal_we_i = 1'b1; pal_addr_i = 2'd3; pal_data_i = 24'h0a0b0c;
        R_i = 5'h15; G_i = 5'h0a; B_i = 5'h1f;
        cycle();
        pal_we_i = 1'b0;
        repeat (4) cycle();
        chk_rgb("pre_reset", 8'h0a, 8'h0b, 8'h0c);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk_rgb("async_rst", 8'h00, 8'h00, 8'h00);
        chk("async_rst_DE", 32'(DE_o), 32'h0);
        chk("async_rst_HS", 32'(HSYNC_o), 32'h1);
        chk("async_rst_VS", 32'(VSYNC_o), 32'h1);
        chk("async_rst_FS", 32'(frame_start_o), 32'h0);
        do_reset();
        DE_i = 1'b1; osd_enable_i = 1'b1; osd_color_i = 2'd3;
        R_i = 5'h15; G_i = 5'h0a; B_i = 5'h1f;
        repeat (4) cycle();
        chk_rgb("pal_default_again", 8'hff, 8'hff, 8'hff);
        for (int t = 0; t < 200; t++) begin
            VSYNC_i      = ((t % 50) < 5) ? 1'b0 : 1'b1;
            R_i          = IN_BITS'($urandom);
            blend_mode_i = 1'b1;
            cycle();
        end

        // drain the pipeline
        repeat (3) @(negedge PCLK_i);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
